c7b_biu_rd_arb: RTL and testbench
=================================

// Module: c7b_biu_rd_arb
// PURPOSE
//  Read-port arbiter between IFU fetch and LSU load for the single bus read channel of c7b.
//  Sits between u_core and the bus interface; one transaction outstanding at a time.
//  Captures the request, drives the address phase, waits for data and returns a registered response to the owner.
// PARAMETERS
//  AW           32  address width
//  DW           32  data width
//  STARVE_LIMIT 4   consecutive LSU grants with IFU waiting before IFU is forced (guard build only); >=1
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  flush          in   1   pipeline redirect; cancels the IFU transaction
//  ifu_req_valid  in   1   fetch request
//  ifu_req_ready  out  1   fetch request accepted this cycle
//  ifu_req_addr   in   AW  fetch address, word aligned
//  ifu_resp_valid out  1   one-cycle pulse, fetch data valid
//  ifu_resp_data  out  DW  fetch data
//  lsu_req_valid  in   1   load request
//  lsu_req_ready  out  1   load request accepted this cycle
//  lsu_req_addr   in   AW  load address
//  lsu_req_size   in   2   0=byte 1=half 2=word
//  lsu_resp_valid out  1   one-cycle pulse, load data valid
//  lsu_resp_data  out  DW  load data, raw bus word
//  ar_valid       out  1   bus address valid
//  ar_ready       in   1   bus address accepted
//  ar_addr        out  AW  bus address
//  ar_size        out  2   bus size (IFU always 2)
//  r_valid        in   1   bus data valid
//  r_ready        out  1   bus data accept
//  r_data         in   DW  bus data
// BEHAVIOUR
//  Reset: state IDLE, owner none, drop 0, starve count 0; all outputs 0 (addr/data 0).
//  FSM IDLE->ADDR->DATA->RESP->IDLE.
//  IDLE: grant one requester; *_req_ready=1 only to the granted one (combinational on valids, flush).
//    Priority LSU>IFU; if flush=1, IFU is not granted that cycle. Handshake captures addr/size -> ADDR.
//  ADDR: ar_valid=1, ar_addr/ar_size stable until ar_ready; on ar_ready -> DATA (ar_valid low next cycle).
//  DATA: r_ready=1; on r_valid latch r_data -> RESP.
//  RESP: owner's resp_valid=1 for exactly one cycle with latched data -> IDLE. No grant in RESP.
//  Min latency: req handshake cycle N, ar_valid N+1, r_valid N+2 at earliest, resp_valid N+3.
//  Flush: if owner=IFU in ADDR/DATA/RESP, set drop. The bus transaction still completes; ifu_resp_valid is suppressed.
//    drop clears on return to IDLE. Flush never affects an LSU transaction.
//  *_req_ready is never 1 outside IDLE; a requester holds valid/addr until ready.
//  r_valid outside DATA is ignored (bus shares this reset; no stale beats).
//  Reset mid-transaction: immediate return to IDLE next cycle, outputs 0, no response.
// CONFIGURATION
//  C7B_ARB_STARVE_GUARD_EN defined:
//    - Counter increments on each LSU grant while ifu_req_valid=1 and clears on any IFU grant.
//    - When count==STARVE_LIMIT and both requesters are valid (no flush), IFU wins the next grant.
//    - Counter saturates at STARVE_LIMIT.
//  Undefined: strict LSU>IFU priority; no counter logic present.
// STRUCTURE
//  Shared package c7b_biu_pkg: FSM state encoding (IDLE/ADDR/DATA/RESP), owner encoding (NONE/IFU/LSU), size constants.
//  Sub-module c7b_arb_starve_cnt (saturating counter plus force flag), instantiated only under the macro.
// TESTING
//  T1: IFU-only fetch 0x1c000000, ar_ready same cycle, r_valid next, r_data 0x02800405
//      -> ar_addr 0x1c000000 size 2; ifu_resp_valid one cycle at N+3 with 0x02800405.
//  T2: IFU and LSU valid together (LSU 0x1c001000 size 0) -> LSU granted first, then IFU; responses in that order.
//  T3: ar_ready low 3 cycles -> ar_valid/ar_addr stable 4 cycles; no req_ready during wait.
//  T4: flush in DATA of an IFU read -> r_ready still accepts r_valid; ifu_resp_valid stays 0; next IFU request granted.
//  T5: reset=1 while in DATA, then r_valid -> state IDLE, no resp pulse, all outputs 0.
//  T6 (guard build, STARVE_LIMIT=4): IFU held valid, LSU back-to-back -> IFU granted after 4th LSU grant.
//      Non-guard build: IFU waits until LSU drops valid.

Source files
------------

// File: rtl/c7b_biu_pkg.sv
// Shared encodings for the c7b bus-interface read arbiter: FSM states, owner IDs, bus size codes.
package c7b_biu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IFU  = 2'd1,
    OWN_LSU  = 2'd2
  } arb_owner_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage

// File: rtl/c7b_arb_starve_cnt.sv
// IFU starvation guard: counts LSU grants taken while IFU waits, saturating at LIMIT;
// force_ifu tells the arbiter to hand the next contested grant to IFU.
module c7b_arb_starve_cnt #(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic lsu_grant,
  input  logic ifu_grant,
  input  logic ifu_waiting,
  output logic force_ifu
);
  import c7b_biu_pkg::*;

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (ifu_grant) begin
      cnt_d = '0;
    end else if (lsu_grant && ifu_waiting && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_ifu = (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/c7b_biu_rd_arb.sv
// Read-port arbiter (LSU over IFU) for the single c7b bus read channel, one transaction in flight.
// Optional IFU starvation guard enabled by defining C7B_ARB_STARVE_GUARD_EN.
module c7b_biu_rd_arb #(
  parameter int unsigned AW           = 32,
  parameter int unsigned DW           = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          ifu_req_valid,
  output logic          ifu_req_ready,
  input  logic [AW-1:0] ifu_req_addr,
  output logic          ifu_resp_valid,
  output logic [DW-1:0] ifu_resp_data,
  input  logic          lsu_req_valid,
  output logic          lsu_req_ready,
  input  logic [AW-1:0] lsu_req_addr,
  input  logic [1:0]    lsu_req_size,
  output logic          lsu_resp_valid,
  output logic [DW-1:0] lsu_resp_data,
  output logic          ar_valid,
  input  logic          ar_ready,
  output logic [AW-1:0] ar_addr,
  output logic [1:0]    ar_size,
  input  logic          r_valid,
  output logic          r_ready,
  input  logic [DW-1:0] r_data
);
  import c7b_biu_pkg::*;

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic          drop_q,  drop_d;
  logic [AW-1:0] addr_q,  addr_d;
  logic [1:0]    size_q,  size_d;
  logic [DW-1:0] data_q,  data_d;

  logic force_ifu;
  logic ifu_gnt;
  logic lsu_gnt;

`ifdef C7B_ARB_STARVE_GUARD_EN
  c7b_arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk        (clk),
    .reset      (reset),
    .lsu_grant  (lsu_gnt),
    .ifu_grant  (ifu_gnt),
    .ifu_waiting(ifu_req_valid),
    .force_ifu  (force_ifu)
  );
`else
  // Strict LSU priority; STARVE_LIMIT is at least 1 so this is constant 0.
  assign force_ifu = (STARVE_LIMIT == 0);
`endif

  always_comb begin
    ifu_gnt = 1'b0;
    lsu_gnt = 1'b0;
    if ((state_q == ST_IDLE) && !reset) begin
      if (ifu_req_valid && !flush && (force_ifu || !lsu_req_valid)) begin
        ifu_gnt = 1'b1;
      end else if (lsu_req_valid) begin
        lsu_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    drop_d  = drop_q;
    addr_d  = addr_q;
    size_d  = size_q;
    data_d  = data_q;
    unique case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (lsu_gnt) begin
          owner_d = OWN_LSU;
          addr_d  = lsu_req_addr;
          size_d  = lsu_req_size;
          state_d = ST_ADDR;
        end else if (ifu_gnt) begin
          owner_d = OWN_IFU;
          addr_d  = ifu_req_addr;
          size_d  = SIZE_WORD;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_ready) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (r_valid) begin
          data_d  = r_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
        drop_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // The bus beat is still consumed after a redirect; only the fetch response is dropped.
    if (flush && (owner_q == OWN_IFU) && ((state_q == ST_ADDR) || (state_q == ST_DATA))) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_NONE;
      drop_q  <= 1'b0;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      drop_q  <= drop_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
    end
  end

  assign ifu_req_ready  = ifu_gnt;
  assign lsu_req_ready  = lsu_gnt;

  assign ar_valid       = (state_q == ST_ADDR);
  assign ar_addr        = ar_valid ? addr_q : '0;
  assign ar_size        = ar_valid ? size_q : '0;
  assign r_ready        = (state_q == ST_DATA);

  assign ifu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_IFU) && !drop_q;
  assign lsu_resp_valid = (state_q == ST_RESP) && (owner_q == OWN_LSU);
  assign ifu_resp_data  = ifu_resp_valid ? data_q : '0;
  assign lsu_resp_data  = lsu_resp_valid ? data_q : '0;

endmodule

// File: tb/tb_c7b_biu_rd_arb.sv
// Self-checking bench for c7b_biu_rd_arb: directed scenarios plus random traffic against a
// transaction-level reference model. Honours C7B_ARB_STARVE_GUARD_EN like the design.
module tb_c7b_biu_rd_arb;

  localparam int unsigned LIM = 4;
`ifdef C7B_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_req_addr, ifu_resp_data;
  logic        lsu_req_valid, lsu_req_ready, lsu_resp_valid;
  logic [31:0] lsu_req_addr, lsu_resp_data;
  logic [1:0]  lsu_req_size;
  logic        ar_valid, ar_ready, r_valid, r_ready;
  logic [31:0] ar_addr, r_data;
  logic [1:0]  ar_size;

  always #5 clk = ~clk;

  c7b_biu_rd_arb #(
    .AW(32),
    .DW(32),
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_size(lsu_req_size), .lsu_resp_valid(lsu_resp_valid), .lsu_resp_data(lsu_resp_data),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_size(ar_size),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data)
  );

  int checks = 0;
  int errors = 0;

  // Reference: one in-flight transaction record with progress flags (owner 1=IFU, 2=LSU).
  bit          m_busy, m_sent, m_got, m_drop;
  int          m_owner;
  logic [31:0] m_addr, m_data;
  logic [1:0]  m_size;
  int          m_starve;

  int          resp_q[$];
  int          n, lsu_cnt, ifu_at;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Who should be accepted right now, from the arbitration rules.
  function automatic void predict(output bit ig, output bit lg);
    bit ifu_forced;
    bit ifu_ok;
    ig = 1'b0;
    lg = 1'b0;
    ifu_forced = GUARD && (m_starve >= int'(LIM));
    ifu_ok     = ifu_req_valid && !flush;
    if (!m_busy && !reset) begin
      if (lsu_req_valid && !(ifu_forced && ifu_ok)) lg = 1'b1;
      else if (ifu_ok) ig = 1'b1;
    end
  endfunction

  task automatic settle();
    bit ig, lg, ar_exp, rsp;
    #2;
    predict(ig, lg);
    ar_exp = m_busy && !m_sent;
    rsp    = m_busy && m_got;
    chk("ifu_req_ready", ifu_req_ready, ig);
    chk("lsu_req_ready", lsu_req_ready, lg);
    chk("ar_valid", ar_valid, ar_exp);
    chk("ar_addr", ar_addr, ar_exp ? m_addr : 32'h0);
    chk("ar_size", ar_size, ar_exp ? m_size : 2'd0);
    chk("r_ready", r_ready, m_busy && m_sent && !m_got);
    chk("ifu_resp_valid", ifu_resp_valid, rsp && (m_owner == 1) && !m_drop);
    chk("ifu_resp_data", ifu_resp_data, (rsp && (m_owner == 1) && !m_drop) ? m_data : 32'h0);
    chk("lsu_resp_valid", lsu_resp_valid, rsp && (m_owner == 2));
    chk("lsu_resp_data", lsu_resp_data, (rsp && (m_owner == 2)) ? m_data : 32'h0);
  endtask

  task automatic edge_();
    bit ig, lg;
    predict(ig, lg);
    @(posedge clk);
    if (reset) begin
      m_busy = 0; m_sent = 0; m_got = 0; m_drop = 0; m_owner = 0; m_starve = 0;
    end else if (!m_busy) begin
      if (lg) begin
        m_busy = 1; m_sent = 0; m_got = 0; m_drop = 0; m_owner = 2;
        m_addr = lsu_req_addr; m_size = lsu_req_size;
        if (ifu_req_valid && m_starve < int'(LIM)) m_starve++;
      end else if (ig) begin
        m_busy = 1; m_sent = 0; m_got = 0; m_drop = 0; m_owner = 1;
        m_addr = ifu_req_addr; m_size = 2'd2;
        m_starve = 0;
      end
    end else if (m_got) begin
      m_busy = 0; m_owner = 0; m_drop = 0;
    end else begin
      if (flush && m_owner == 1) m_drop = 1;
      if (!m_sent) begin
        if (ar_ready) m_sent = 1;
      end else if (r_valid) begin
        m_got = 1; m_data = r_data;
      end
    end
    #1;
    if (ig) ifu_req_valid = 1'b0;
    if (lg) lsu_req_valid = 1'b0;
  endtask

  task automatic tick();
    settle();
    edge_();
  endtask

  task automatic drain(input int cycles);
    ar_ready = 1'b1;
    r_valid  = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      r_data = $urandom;
      tick();
    end
    r_valid  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_size = '0;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0;
    m_busy = 0; m_sent = 0; m_got = 0; m_drop = 0; m_owner = 0; m_starve = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    tick();
    settle();
    chk("rst_outputs", {ar_valid, r_ready, ifu_resp_valid, lsu_resp_valid, ar_addr, ifu_resp_data},
        {4'b0, 32'h0, 32'h0});
    edge_();
    reset = 1'b0;

    // T1: lone fetch at minimum latency
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000000; ar_ready = 1'b1;
    settle(); chk("t1_handshake", ifu_req_ready, 1'b1); edge_();
    settle(); chk("t1_ar_addr", ar_addr, 32'h1c000000); chk("t1_ar_size", ar_size, 2'd2); edge_();
    r_valid = 1'b1; r_data = 32'h02800405;
    settle(); chk("t1_r_ready", r_ready, 1'b1); edge_();
    r_valid = 1'b0;
    settle(); chk("t1_resp_valid", ifu_resp_valid, 1'b1); chk("t1_resp_data", ifu_resp_data, 32'h02800405); edge_();
    settle(); chk("t1_resp_pulse", ifu_resp_valid, 1'b0); edge_();

    // T2: simultaneous requests, LSU served first
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000040;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h1c001000; lsu_req_size = 2'd0;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'hcafe0001;
    resp_q.delete();
    for (int i = 0; i < 12; i++) begin
      settle();
      if (ifu_resp_valid) resp_q.push_back(1);
      if (lsu_resp_valid) resp_q.push_back(2);
      edge_();
    end
    r_valid = 1'b0;
    chk("t2_resp_count", resp_q.size(), 2);
    chk("t2_first_lsu", (resp_q.size() > 0) ? resp_q[0] : 0, 2);
    chk("t2_second_ifu", (resp_q.size() > 1) ? resp_q[1] : 0, 1);

    // T3: address phase stalled by ar_ready
    ar_ready = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000080;
    tick();
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h1c002000; lsu_req_size = 2'd1;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); n += int'(ar_valid); chk("t3_no_ready", lsu_req_ready, 1'b0); edge_();
    end
    ar_ready = 1'b1;
    settle(); n += int'(ar_valid); chk("t3_ar_addr", ar_addr, 32'h1c000080); edge_();
    chk("t3_ar_cycles", n, 4);
    drain(10);

    // T4: redirect during the data phase of a fetch
    ar_ready = 1'b1; r_valid = 1'b0; ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c0000c0;
    tick(); tick();
    flush = 1'b1; r_valid = 1'b1; r_data = 32'hdeadbeef;
    settle(); chk("t4_r_ready", r_ready, 1'b1); edge_();
    flush = 1'b0; r_valid = 1'b0;
    n = 0;
    for (int i = 0; i < 3; i++) begin
      settle(); n += int'(ifu_resp_valid); edge_();
    end
    chk("t4_suppressed", n, 0);
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000100;
    settle(); chk("t4_regrant", ifu_req_ready, 1'b1); edge_();
    drain(6);

    // T5: reset while waiting for data
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000140; ar_ready = 1'b1; r_valid = 1'b0;
    tick(); tick();
    reset = 1'b1; r_valid = 1'b1; r_data = 32'h12345678;
    settle(); chk("t5_in_data", r_ready, 1'b1); edge_();
    reset = 1'b0;
    settle();
    chk("t5_outputs", {ar_valid, r_ready, ifu_resp_valid, lsu_resp_valid, ar_addr, ifu_resp_data},
        {4'b0, 32'h0, 32'h0});
    edge_();
    settle(); chk("t5_no_resp", ifu_resp_valid, 1'b0); edge_();
    r_valid = 1'b0;

    // T6: IFU held while LSU streams six back-to-back loads
    do_reset();
    ifu_req_valid = 1'b1; ifu_req_addr = 32'h1c000180;
    lsu_req_valid = 1'b1; lsu_req_addr = 32'h1c003000; lsu_req_size = 2'd2;
    ar_ready = 1'b1; r_valid = 1'b1; r_data = 32'h0badf00d;
    lsu_cnt = 0; ifu_at = -1;
    for (int i = 0; i < 60 && ifu_at < 0; i++) begin
      settle();
      if (ifu_req_ready) ifu_at = lsu_cnt;
      if (lsu_req_ready) lsu_cnt++;
      edge_();
      if (lsu_cnt < 6 && ifu_at < 0 && !lsu_req_valid) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr  = $urandom & 32'hffff_fffc;
      end
    end
    chk("t6_ifu_after_lsu", ifu_at, GUARD ? 4 : 6);
    drain(12);

    // Random traffic
    for (int c = 0; c < 2500; c++) begin
      if (!ifu_req_valid && ($urandom_range(2) == 0)) begin
        ifu_req_valid = 1'b1;
        ifu_req_addr  = $urandom & 32'hffff_fffc;
      end
      if (!lsu_req_valid && ($urandom_range(2) == 0)) begin
        lsu_req_valid = 1'b1;
        lsu_req_addr  = $urandom;
        lsu_req_size  = 2'($urandom_range(2));
      end
      flush    = ($urandom_range(7) == 0);
      ar_ready = ($urandom_range(1) == 0);
      r_valid  = ($urandom_range(2) == 0);
      r_data   = $urandom;
      reset    = ($urandom_range(149) == 0);
      tick();
    end
    reset = 1'b0; flush = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
